alu_exec: RTL and testbench

ALU_EXEC -- requirements
Module: alu_exec

---
 rtl/alu_exec_pkg.sv | 73 +++++++
 rtl/alu_exec_core.sv | 51 +++++
 rtl/alu_exec.sv | 114 +++++++++++
 tb/tb_alu_exec.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_pkg.sv
// Shared execution-unit definitions: op class/func codes, tag widths and the
// partial-result bundle passed from alu_core into the E1 register.
package alu_exec_pkg;

    localparam int XLEN     = 32;
    localparam int TAG_W    = 4;
    // RS operand fields carry one extra bit so "no tag" (16) is distinct from any ROB tag.
    localparam int RS_TAG_W = TAG_W + 1;
    localparam logic [RS_TAG_W-1:0] NO_TAG = RS_TAG_W'(16);

    typedef logic [TAG_W-1:0] tag_t;

    // Op classes (opt[5:3])
    localparam logic [2:0] CLS_ALU   = 3'b000;
    localparam logic [2:0] CLS_ALU2  = 3'b001;
    localparam logic [2:0] CLS_ALUI  = 3'b010;
    localparam logic [2:0] CLS_ALUI2 = 3'b011;
    localparam logic [2:0] CLS_BR    = 3'b100;

    // Func codes (opt[2:0]) for classes 000 / 010
    localparam logic [2:0] FN_ADD  = 3'd0;
    localparam logic [2:0] FN_SUB  = 3'd1;
    localparam logic [2:0] FN_SLL  = 3'd2;
    localparam logic [2:0] FN_SLT  = 3'd3;
    localparam logic [2:0] FN_SLTU = 3'd4;
    localparam logic [2:0] FN_XOR  = 3'd5;
    localparam logic [2:0] FN_SRL  = 3'd6;
    localparam logic [2:0] FN_SRA  = 3'd7;
    // Func codes for classes 001 / 011
    localparam logic [2:0] FN_OR   = 3'd0;
    localparam logic [2:0] FN_AND  = 3'd1;
    localparam logic [2:0] FN_LUI  = 3'd2;
    // Func codes for class 100
    localparam logic [2:0] FN_BEQ  = 3'd0;
    localparam logic [2:0] FN_BNE  = 3'd1;
    localparam logic [2:0] FN_BLT  = 3'd2;
    localparam logic [2:0] FN_BGE  = 3'd3;
    localparam logic [2:0] FN_BLTU = 3'd4;
    localparam logic [2:0] FN_BGEU = 3'd5;

    // Results computed in E1; E2 only selects among them.
    typedef struct packed {
        logic [XLEN-1:0] sum;      // op1 + op2, or op1 - op2 for SUB
        logic [XLEN-1:0] shift;    // SLL/SRL/SRA result
        logic [XLEN-1:0] bitwise;  // XOR/OR/AND/LUI result
        logic            eq;
        logic            lt_s;
        logic            lt_u;
        logic            legal;
    } alu_partial_t;

    // True when the class/func pair names a defined operation.
    function automatic logic op_legal(input logic [5:0] opt);
        logic [2:0] cls;
        logic [2:0] fn;
        cls = opt[5:3];
        fn  = opt[2:0];
        case (cls)
            CLS_ALU:   op_legal = 1'b1;
            CLS_ALU2:  op_legal = (fn <= FN_AND);
            CLS_ALUI:  op_legal = (fn != FN_SUB);
            CLS_ALUI2: op_legal = (fn <= FN_LUI);
            CLS_BR:    op_legal = (fn <= FN_BGEU);
            default:   op_legal = 1'b0;
        endcase
    endfunction

    // Immediate-operand classes take op2 from imm instead of rs2.
    function automatic logic uses_imm(input logic [2:0] cls);
        uses_imm = (cls == CLS_ALUI) || (cls == CLS_ALUI2);
    endfunction

endpackage

// File: rtl/alu_exec_core.sv
// Combinational op evaluation: produces adder, shifter, bitwise and compare
// partial results for one operand pair.
module alu_core
    import alu_exec_pkg::*;
(
    input  logic [5:0]      opt,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output alu_partial_t    part
);

    logic [2:0] cls;
    logic [2:0] fn;
    logic [4:0] shamt;

    assign cls   = opt[5:3];
    assign fn    = opt[2:0];
    assign shamt = op2[4:0];

    // Evaluate every functional unit in parallel; E2 picks the one the op needs.
    always_comb begin
        // NOTE: default every output first so no path through the case leaves a latch.
        part = '0;

        part.sum = ((cls == CLS_ALU) && (fn == FN_SUB)) ? (op1 - op2) : (op1 + op2);

        case (fn)
            FN_SLL:  part.shift = op1 << shamt;
            FN_SRL:  part.shift = op1 >> shamt;
            FN_SRA:  part.shift = $unsigned($signed(op1) >>> shamt);
            default: part.shift = '0;
        endcase

        if ((cls == CLS_ALU2) || (cls == CLS_ALUI2)) begin
            case (fn)
                FN_OR:   part.bitwise = op1 | op2;
                FN_AND:  part.bitwise = op1 & op2;
                FN_LUI:  part.bitwise = op2;
                default: part.bitwise = '0;
            endcase
        end else begin
            part.bitwise = op1 ^ op2;
        end

        part.eq    = (op1 == op2);
        part.lt_s  = ($signed(op1) < $signed(op2));
        part.lt_u  = (op1 < op2);
        part.legal = op_legal(opt);
    end

endmodule

// File: rtl/alu_exec.sv
// Two-stage integer execution pipeline: E1 registers the op and its partial
// results, E2 selects the final value and broadcasts it on CDB_1.
module alu_exec
    import alu_exec_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            clear,
    input  logic            from_rs_ok,
    input  logic [5:0]      from_rs_opt,
    input  logic [XLEN-1:0] from_rs_rs1,
    input  logic [XLEN-1:0] from_rs_rs2,
    input  logic [XLEN-1:0] from_rs_imm,
    input  tag_t            from_rs_en,
    output logic            CDB_1_ok,
    output tag_t            CDB_1_en,
    output logic [XLEN-1:0] CDB_1_val,
    output logic            illegal
);

    logic [XLEN-1:0] op2;
    alu_partial_t    core_part;

    logic            e1_valid;
    logic [5:0]      e1_opt;
    tag_t            e1_tag;
    alu_partial_t    e1_part;
    logic [XLEN-1:0] e2_result;

    assign op2 = uses_imm(from_rs_opt[5:3]) ? from_rs_imm : from_rs_rs2;

    alu_core u_core (
        .opt  (from_rs_opt),
        .op1  (from_rs_rs1),
        .op2  (op2),
        .part (core_part)
    );

    // Valid bits: reset beats clear, clear beats rdy, rdy low freezes.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            e1_valid <= 1'b0;
            CDB_1_ok <= 1'b0;
        end else if (clear) begin
            e1_valid <= 1'b0;
            CDB_1_ok <= 1'b0;
        end else if (rdy) begin
            e1_valid <= from_rs_ok;
            CDB_1_ok <= e1_valid;
        end
    end

    // E1 payload: loaded only on an accepted issue.
    always_ff @(posedge clk) begin
        // NOTE: payload needs no reset; e1_valid alone decides whether it is ever used.
        if (!rst && !clear && rdy && from_rs_ok) begin
            e1_opt  <= from_rs_opt;
            e1_tag  <= from_rs_en;
            e1_part <= core_part;
        end
    end

    // E2 result select from the registered partials.
    always_comb begin
        e2_result = '0;
        case (e1_opt[5:3])
            CLS_ALU, CLS_ALUI: begin
                case (e1_opt[2:0])
                    FN_ADD, FN_SUB:         e2_result = e1_part.sum;
                    FN_SLL, FN_SRL, FN_SRA: e2_result = e1_part.shift;
                    FN_SLT:                 e2_result = {31'd0, e1_part.lt_s};
                    FN_SLTU:                e2_result = {31'd0, e1_part.lt_u};
                    default:                e2_result = e1_part.bitwise;
                endcase
            end
            CLS_ALU2, CLS_ALUI2: e2_result = e1_part.bitwise;
            CLS_BR: begin
                case (e1_opt[2:0])
                    FN_BEQ:  e2_result = {31'd0,  e1_part.eq};
                    FN_BNE:  e2_result = {31'd0, ~e1_part.eq};
                    FN_BLT:  e2_result = {31'd0,  e1_part.lt_s};
                    FN_BGE:  e2_result = {31'd0, ~e1_part.lt_s};
                    FN_BLTU: e2_result = {31'd0,  e1_part.lt_u};
                    FN_BGEU: e2_result = {31'd0, ~e1_part.lt_u};
                    default: e2_result = '0;
                endcase
            end
            default: e2_result = '0;
        endcase
        if (!e1_part.legal) begin
            e2_result = '0;
        end
    end

    // E2 broadcast registers: tag/value hold across bubbles, illegal tracks CDB_1_ok.
    always_ff @(posedge clk) begin
        if (rst) begin
            CDB_1_en  <= '0;
            CDB_1_val <= '0;
            illegal   <= 1'b0;
        end else if (clear) begin
            illegal   <= 1'b0;
        end else if (rdy) begin
            illegal <= e1_valid && !e1_part.legal;
            if (e1_valid) begin
                CDB_1_en  <= e1_tag;
                CDB_1_val <= e2_result;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// Directed self-checking bench for alu_exec.
module tb_alu_exec;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        clear;
    logic        from_rs_ok;
    logic [5:0]  from_rs_opt;
    logic [31:0] from_rs_rs1;
    logic [31:0] from_rs_rs2;
    logic [31:0] from_rs_imm;
    logic [3:0]  from_rs_en;
    logic        CDB_1_ok;
    logic [3:0]  CDB_1_en;
    logic [31:0] CDB_1_val;
    logic        illegal;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [5:0]  opt;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [31:0] exp;
        logic        ill;
    } vec_t;

    alu_exec dut (
        .clk         (clk),
        .rst         (rst),
        .rdy         (rdy),
        .clear       (clear),
        .from_rs_ok  (from_rs_ok),
        .from_rs_opt (from_rs_opt),
        .from_rs_rs1 (from_rs_rs1),
        .from_rs_rs2 (from_rs_rs2),
        .from_rs_imm (from_rs_imm),
        .from_rs_en  (from_rs_en),
        .CDB_1_ok    (CDB_1_ok),
        .CDB_1_en    (CDB_1_en),
        .CDB_1_val   (CDB_1_val),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ok, input logic [5:0] opt, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] imm, input logic [3:0] tag);
        from_rs_ok  = ok;
        from_rs_opt = opt;
        from_rs_rs1 = rs1;
        from_rs_rs2 = rs2;
        from_rs_imm = imm;
        from_rs_en  = tag;
    endtask

    task automatic idle();
        drive(1'b0, 6'h3F, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 4'hF);
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        idle();
        tick(); tick();
        rst = 1'b0;
        checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL reset_ok got=%b want=0", CDB_1_ok); end
        checks++; if (CDB_1_en !== 4'd0) begin errors++; $display("FAIL reset_en got=%0d want=0", CDB_1_en); end
        checks++; if (CDB_1_val !== 32'd0) begin errors++; $display("FAIL reset_val got=%h want=0", CDB_1_val); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    endtask

    task automatic test_add_latency();
        drive(1'b1, 6'o00, 32'd5, 32'd7, 32'hFFFF0000, 4'd3);
        tick();
        idle();
        checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL add_early got=%b want=0", CDB_1_ok); end
        tick();
        checks++; if (CDB_1_ok !== 1'b1) begin errors++; $display("FAIL add_ok got=%b want=1", CDB_1_ok); end
        checks++; if (CDB_1_en !== 4'd3) begin errors++; $display("FAIL add_en got=%0d want=3", CDB_1_en); end
        checks++; if (CDB_1_val !== 32'd12) begin errors++; $display("FAIL add_val got=%h want=c", CDB_1_val); end
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got=%b want=0", illegal); end
        tick();
        checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL bubble_ok got=%b want=0", CDB_1_ok); end
        checks++; if (CDB_1_en !== 4'd3) begin errors++; $display("FAIL bubble_en_hold got=%0d want=3", CDB_1_en); end
        checks++; if (CDB_1_val !== 32'd12) begin errors++; $display("FAIL bubble_val_hold got=%h want=c", CDB_1_val); end
    endtask

    task automatic test_shift();
        drive(1'b1, 6'o27, 32'h80000000, 32'hDEADBEEF, 32'd4, 4'd1);   // SRAI
        tick();
        drive(1'b1, 6'o06, 32'h80000000, 32'd4, 32'hFFFFFFFF, 4'd2);   // SRL, stale imm
        tick();
        idle();
        checks++; if (CDB_1_val !== 32'hF8000000 || CDB_1_ok !== 1'b1) begin errors++; $display("FAIL srai got=%h ok=%b want=f8000000 ok=1", CDB_1_val, CDB_1_ok); end
        tick();
        checks++; if (CDB_1_val !== 32'h08000000 || CDB_1_en !== 4'd2) begin errors++; $display("FAIL srl got=%h en=%0d want=08000000 en=2", CDB_1_val, CDB_1_en); end
        tick();
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 6'o03, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd1);          // SLT
        tick();
        drive(1'b1, 6'o04, 32'hFFFFFFFF, 32'd1, 32'd0, 4'd2);          // SLTU
        tick();
        idle();
        checks++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd1 || CDB_1_val !== 32'd1) begin errors++; $display("FAIL slt_b2b got ok=%b en=%0d val=%h want ok=1 en=1 val=1", CDB_1_ok, CDB_1_en, CDB_1_val); end
        tick();
        checks++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd2 || CDB_1_val !== 32'd0) begin errors++; $display("FAIL sltu_b2b got ok=%b en=%0d val=%h want ok=1 en=2 val=0", CDB_1_ok, CDB_1_en, CDB_1_val); end
        tick();
        checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL b2b_end got=%b want=0", CDB_1_ok); end
    endtask

    task automatic test_op_table();
        vec_t v[$];
        v.push_back('{"sub_pos",  6'o01, 32'd10, 32'd3, 32'd99, 32'd7, 1'b0});
        v.push_back('{"sub_neg",  6'o01, 32'd3, 32'd10, 32'd99, 32'hFFFFFFF9, 1'b0});
        v.push_back('{"sll_wrap", 6'o02, 32'd1, 32'd33, 32'd0, 32'd2, 1'b0});
        v.push_back('{"xor",      6'o05, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'h0FF00FF0, 1'b0});
        v.push_back('{"sra_zero", 6'o07, 32'h80000000, 32'd32, 32'd0, 32'h80000000, 1'b0});
        v.push_back('{"or",       6'o10, 32'h0F, 32'hF0, 32'd0, 32'hFF, 1'b0});
        v.push_back('{"and",      6'o11, 32'hFF, 32'h0F, 32'd0, 32'h0F, 1'b0});
        v.push_back('{"addi",     6'o20, 32'd1, 32'd5, 32'hFFFFFFFF, 32'd0, 1'b0});
        v.push_back('{"slli",     6'o22, 32'd3, 32'd0, 32'd4, 32'h30, 1'b0});
        v.push_back('{"slti",     6'o23, 32'hFFFFFFFB, 32'd0, 32'd3, 32'd1, 1'b0});
        v.push_back('{"sltiu",    6'o24, 32'd3, 32'd0, 32'hFFFFFFFB, 32'd1, 1'b0});
        v.push_back('{"xori",     6'o25, 32'd1, 32'd7, 32'd3, 32'd2, 1'b0});
        v.push_back('{"srli",     6'o26, 32'hF0000000, 32'd0, 32'd28, 32'hF, 1'b0});
        v.push_back('{"ori",      6'o30, 32'h10, 32'h0, 32'h01, 32'h11, 1'b0});
        v.push_back('{"andi",     6'o31, 32'h13, 32'hFF, 32'h06, 32'h02, 1'b0});
        v.push_back('{"lui",      6'o32, 32'h1234, 32'h5678, 32'hABCDE000, 32'hABCDE000, 1'b0});
        v.push_back('{"beq",      6'o40, 32'd5, 32'd5, 32'd0, 32'd1, 1'b0});
        v.push_back('{"bne",      6'o41, 32'd5, 32'd5, 32'd0, 32'd0, 1'b0});
        v.push_back('{"blt",      6'o42, 32'hFFFFFFFF, 32'd0, 32'd0, 32'd1, 1'b0});
        v.push_back('{"bge",      6'o43, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd1, 1'b0});
        v.push_back('{"bltu",     6'o44, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd1, 1'b0});
        v.push_back('{"bgeu",     6'o45, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 1'b0});
        v.push_back('{"ill_21",   6'o21, 32'd1, 32'd2, 32'd3, 32'd0, 1'b1});
        v.push_back('{"ill_12",   6'o12, 32'd7, 32'd7, 32'd0, 32'd0, 1'b1});
        v.push_back('{"ill_33",   6'o33, 32'd7, 32'd7, 32'd7, 32'd0, 1'b1});
        v.push_back('{"ill_46",   6'o46, 32'd1, 32'd1, 32'd0, 32'd0, 1'b1});
        v.push_back('{"ill_71",   6'o71, 32'd9, 32'd9, 32'd9, 32'd0, 1'b1});
        for (int i = 0; i < v.size(); i++) begin
            drive(1'b1, v[i].opt, v[i].rs1, v[i].rs2, v[i].imm, 4'(i));
            tick();
            idle();
            tick();
            checks++; if (CDB_1_val !== v[i].exp) begin errors++; $display("FAIL %s_val got=%h want=%h", v[i].name, CDB_1_val, v[i].exp); end
            checks++; if (illegal !== v[i].ill) begin errors++; $display("FAIL %s_illegal got=%b want=%b", v[i].name, illegal, v[i].ill); end
            checks++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'(i)) begin errors++; $display("FAIL %s_tag got ok=%b en=%0d want ok=1 en=%0d", v[i].name, CDB_1_ok, CDB_1_en, i); end
        end
        tick();
        checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL illegal_drop got=%b want=0", illegal); end
    endtask

    task automatic test_clear();
        drive(1'b1, 6'o00, 32'd1, 32'd1, 32'd0, 4'd4);
        tick();
        clear = 1'b1;
        drive(1'b1, 6'o00, 32'd2, 32'd2, 32'd0, 4'd5);
        tick();
        clear = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL clear_flush cycle=%0d got=%b want=0", i, CDB_1_ok); end
            tick();
        end
        // clear while stalled
        drive(1'b1, 6'o00, 32'd3, 32'd3, 32'd0, 4'd8);
        tick();
        rdy = 1'b0;
        clear = 1'b1;
        idle();
        tick();
        rdy = 1'b1;
        clear = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL clear_stalled cycle=%0d got=%b want=0", i, CDB_1_ok); end
        end
        // fresh issue after clear still works
        drive(1'b1, 6'o00, 32'd20, 32'd22, 32'd0, 4'd11);
        tick();
        idle();
        tick();
        checks++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd11 || CDB_1_val !== 32'd42) begin errors++; $display("FAIL post_clear got ok=%b en=%0d val=%h want ok=1 en=11 val=2a", CDB_1_ok, CDB_1_en, CDB_1_val); end
        tick();
    endtask

    task automatic test_stall();
        drive(1'b1, 6'o00, 32'd1, 32'd2, 32'd0, 4'd6);
        tick();
        rdy = 1'b0;
        drive(1'b1, 6'o01, 32'd100, 32'd1, 32'd0, 4'd13);   // must be ignored
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL stall_wait cycle=%0d got=%b want=0", i, CDB_1_ok); end
        end
        rdy = 1'b1;
        idle();
        tick();
        checks++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd6 || CDB_1_val !== 32'd3) begin errors++; $display("FAIL stall_result got ok=%b en=%0d val=%h want ok=1 en=6 val=3", CDB_1_ok, CDB_1_en, CDB_1_val); end
        // freeze while the broadcast is up
        rdy = 1'b0;
        tick();
        checks++; if (CDB_1_ok !== 1'b1 || CDB_1_en !== 4'd6) begin errors++; $display("FAIL stall_hold got ok=%b en=%0d want ok=1 en=6", CDB_1_ok, CDB_1_en); end
        rdy = 1'b1;
        tick();
        checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL stall_no_dup got=%b want=0", CDB_1_ok); end
        // class 110 op
        drive(1'b1, 6'o62, 32'd5, 32'd6, 32'd7, 4'd7);
        tick();
        idle();
        tick();
        checks++; if (illegal !== 1'b1 || CDB_1_val !== 32'd0 || CDB_1_en !== 4'd7 || CDB_1_ok !== 1'b1) begin errors++; $display("FAIL class6 got ill=%b val=%h en=%0d ok=%b want ill=1 val=0 en=7 ok=1", illegal, CDB_1_val, CDB_1_en, CDB_1_ok); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 6'o00, 32'd9, 32'd9, 32'd0, 4'd12);
        tick();
        rst = 1'b1;
        clear = 1'b1;
        drive(1'b1, 6'o00, 32'd8, 32'd8, 32'd0, 4'd14);
        tick();
        rst = 1'b0;
        clear = 1'b0;
        idle();
        checks++; if (CDB_1_en !== 4'd0 || CDB_1_val !== 32'd0) begin errors++; $display("FAIL rst_mid_regs got en=%0d val=%h want en=0 val=0", CDB_1_en, CDB_1_val); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (CDB_1_ok !== 1'b0) begin errors++; $display("FAIL rst_mid_ok cycle=%0d got=%b want=0", i, CDB_1_ok); end
        end
    endtask

    initial begin
        test_reset();
        test_add_latency();
        test_shift();
        test_back_to_back();
        test_op_table();
        test_clear();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
